ble_at_responder: RTL and testbench
===================================

# ble_at_responder

Line-oriented AT-command responder: the module-side counterpart of the BLE setup initiator. It pops command bytes from a UART RX FIFO and assembles each CR/LF-terminated line. It then answers on the UART TX FIFO with `OK\r\n` if the line is accepted, or `ERROR\r\n` if not. It sits in the processing subsystem as a synthesizable BLE module model, used for loopback bring-up and for closed-loop verification of the setup flow, including retry and timeout paths.

## Interface
- `MAX_CMD_LEN`, 32: maximum line length in bytes, `\r\n` included.
- `RESP_DELAY`, 16: idle cycles between popping the terminating `\n` and the first response byte (0 allowed; 16-bit range).
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: responder active. Deassertion aborts any operation.
- `rx_valid`  in  1: RX FIFO non-empty; `rx_byte` valid (first-word fall-through).
- `rx_byte`  in  8: head byte of RX FIFO.
- `rx_rd`  out  1: pop strobe, one cycle per byte.
- `tx_full`  in  1: TX FIFO full.
- `tx_wr`  out  1: write strobe for `tx_byte`.
- `tx_byte`  out  8: response byte.
- `busy`  out  1: high in any state other than IDLE.
- `overflow`  out  1: one-cycle pulse when a line exceeds `MAX_CMD_LEN`.
- `ok_count`  out  8: OK responses completed, wrapping.
- `err_count`  out  8: ERROR responses completed, wrapping.
- `inject_err`  in  1: present only with `BLE_RESP_FAULT_EN`. Pulse arms a forced ERROR.
- `inject_drop`  in  1: present only with `BLE_RESP_FAULT_EN`. Pulse arms a silent drop.

## Operation
- States: IDLE, RECV, DISCARD, DELAY, RESP.
- IDLE → RECV when `enable` is high. Clears the length counter, the prefix flags and `last_byte`.
- RECV: if `rx_valid`, assert `rx_rd` and consume `rx_byte` in the same cycle.
  - Byte 0 must be `"A"` and byte 1 must be `"T"`. This sets `prefix_ok`.
  - The length counter increments per byte (width `$clog2(MAX_CMD_LEN+1)+1`).
  - Terminator: `\n` (0x0A) with previous byte `\r` (0x0D). On terminator go to DELAY. The verdict is OK iff `prefix_ok` and length ≤ `MAX_CMD_LEN`.
  - A lone `\n` or `\r` is an ordinary data byte.
  - `"\r\n"` alone and `"A\r\n"` get ERROR. `"AT\r\n"` (length 4) gets OK.
- Overflow: if a byte is consumed while length = `MAX_CMD_LEN` and it is not a terminator, pulse `overflow` and go to DISCARD.
- DISCARD: pops bytes until `\r\n` is seen, then goes to DELAY with verdict ERROR.
- DELAY: counts `RESP_DELAY` cycles, then goes to RESP. `rx_rd` is 0 in DELAY and RESP, so bytes arriving in those states stay in the FIFO.
- RESP: a ROM index walks `O K 0D 0A` (4 bytes) or `E R R O R 0D 0A` (7 bytes).
  - `tx_wr` is high with the current byte only in cycles where `tx_full` = 0; the index then advances.
  - On the last byte, increment `ok_count` or `err_count` and go to RECV.
- `enable` low in any state: IDLE at the next edge. `tx_wr`/`rx_rd` are 0 from that edge on. A partially sent response is abandoned and not counted.

## Timing
- Reset values: `rx_rd`, `tx_wr`, `busy`, `overflow` = 0; `tx_byte` = 0x00; `ok_count` = `err_count` = 0; state IDLE; fault arms cleared.
- Pop latency: `rx_rd` is combinational on `rx_valid` in RECV/DISCARD, so one byte per cycle is possible.
- Response latency: if `\n` is popped at cycle T, the first `tx_wr` is at T+1+`RESP_DELAY`, given `tx_full` = 0.
  - The response is back-to-back: 4 or 7 consecutive cycles without backpressure.
  - Each `tx_full` cycle adds exactly one stall cycle; no byte is dropped or duplicated.
- Counters update in the same cycle as the final `tx_wr`. 0xFF + 1 wraps to 0x00.
- `overflow` is registered: it is high exactly the cycle after the offending pop.
- `busy` drops the cycle after abort or after reset release if `enable` = 0.

## Configuration
- `BLE_RESP_FAULT_EN` defined:
  - Ports `inject_err`/`inject_drop` exist. A pulse sets a sticky arm.
  - The next completed line consumes the arm. `inject_err` forces ERROR. `inject_drop` skips DELAY/RESP (no `tx_wr`, no count change) and returns to RECV.
  - If both are armed, drop wins and both clear.
  - Arms persist across `enable` toggles and clear only on reset or consumption.
- Undefined: ports absent, verdict logic only.

## Test plan
- `RESP_DELAY`=4, feed `"AT\r\n"`: after the `\n` pop, 4 idle cycles, then `tx_wr` on 4 consecutive cycles with 0x4F, 0x4B, 0x0D, 0x0A; `ok_count`=1.
- Feed `"XY\r\n"`, then `"AT+NAME\r\n"`: first gives ERROR (7 bytes), `err_count`=1; second gives OK, `ok_count`=1.
- `MAX_CMD_LEN`=32, feed a 40-byte `"AT…\r\n"` line: `overflow` pulses once after the 33rd pop; the remaining bytes are popped; response is ERROR.
- During an OK response, hold `tx_full` high for 3 cycles after the first byte: `tx_wr` is 0 for those cycles; the exact sequence O,K,0D,0A is still emitted over 7 cycles.
- With `BLE_RESP_FAULT_EN`, pulse `inject_drop`, feed `"AT\r\n"` twice: no TX for the first; OK for the second; `ok_count`=1.
- Deassert `enable` after the 2nd byte of an ERROR response: `tx_wr` is 0 from the next edge, `busy`=0, `err_count` unchanged. Re-enable with `"AT\r\n"`: clean OK.

Source files
------------

// File: rtl/ble_at_responder.sv
`default_nettype none
// ============================================================================
// Module   : ble_at_responder
// Purpose  : Line-oriented AT-command responder (BLE module model). Pops
//            command bytes from a first-word-fall-through RX FIFO, assembles
//            each CR/LF-terminated line and answers "OK\r\n" when the line
//            starts with "AT" and fits in MAX_CMD_LEN bytes, "ERROR\r\n"
//            otherwise. Over-long lines pulse overflow and are drained.
// Ports    : clk, rst_n (async, active-low), enable
//            rx_valid/rx_byte/rx_rd  : RX FIFO head and pop strobe
//            tx_full/tx_wr/tx_byte   : TX FIFO write side
//            busy, overflow, ok_count, err_count : status
//            inject_err/inject_drop  : fault arms (BLE_RESP_FAULT_EN only)
// Config   : `define BLE_RESP_FAULT_EN adds the fault-injection ports/arms.
// Revision : 1.0 - initial release
// ============================================================================
module ble_at_responder #(
    parameter int MAX_CMD_LEN = 32,
    parameter int RESP_DELAY  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
`ifdef BLE_RESP_FAULT_EN
    input  logic       inject_err,
    input  logic       inject_drop,
`endif
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       rx_rd,
    input  logic       tx_full,
    output logic       tx_wr,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] ok_count,
    output logic [7:0] err_count
);

    localparam int                 c_LEN_W   = $clog2(MAX_CMD_LEN + 1) + 1;
    localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_CMD_LEN);
    localparam logic [15:0]        c_DLY     = 16'(RESP_DELAY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_DISCARD = 3'd2,
        S_DELAY   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_LEN_W-1:0] r_len;
    logic               r_a_seen;
    logic               r_prefix_ok;
    logic [7:0]         r_last;
    logic               r_verdict_ok;
    logic [15:0]        r_dly;
    logic [2:0]         r_idx;
    logic               r_overflow;
    logic [7:0]         r_ok_cnt;
    logic [7:0]         r_err_cnt;

    logic               w_is_term;
    logic               w_pop;
    logic               w_term;
    logic               w_line_ok;
    logic               w_ovf;
    logic               w_resp_done;
    logic [2:0]         w_last_idx;
    logic [7:0]         w_rom_byte;
    logic               w_arm_err;
    logic               w_arm_drop;

    // A terminator is LF immediately preceded by CR; either alone is data.
    assign w_is_term  = (rx_byte == 8'h0A) && (r_last == 8'h0D);
    assign w_last_idx = r_verdict_ok ? 3'd3 : 3'd6;

    // Response ROM: "OK\r\n" or "ERROR\r\n" indexed by r_idx.
    always_comb begin
        w_rom_byte = 8'h00;
        if (r_verdict_ok) begin
            case (r_idx)
                3'd0:    w_rom_byte = 8'h4F;
                3'd1:    w_rom_byte = 8'h4B;
                3'd2:    w_rom_byte = 8'h0D;
                3'd3:    w_rom_byte = 8'h0A;
                default: w_rom_byte = 8'h00;
            endcase
        end else begin
            case (r_idx)
                3'd0:    w_rom_byte = 8'h45;
                3'd1:    w_rom_byte = 8'h52;
                3'd2:    w_rom_byte = 8'h52;
                3'd3:    w_rom_byte = 8'h4F;
                3'd4:    w_rom_byte = 8'h52;
                3'd5:    w_rom_byte = 8'h0D;
                3'd6:    w_rom_byte = 8'h0A;
                default: w_rom_byte = 8'h00;
            endcase
        end
    end

    // Next-state and strobe logic.
    always_comb begin
        w_state_nxt = r_state;
        rx_rd       = 1'b0;
        tx_wr       = 1'b0;
        tx_byte     = 8'h00;
        w_pop       = 1'b0;
        w_term      = 1'b0;
        w_line_ok   = 1'b0;
        w_ovf       = 1'b0;
        w_resp_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_RECV;
            end
            S_RECV: begin
                if (rx_valid) begin
                    rx_rd = 1'b1;
                    w_pop = 1'b1;
                    if (w_is_term) begin
                        // Length after this byte is r_len+1; it must not exceed the limit.
                        w_term    = 1'b1;
                        w_line_ok = r_prefix_ok && (r_len < c_MAX_LEN);
                    end else if (r_len == c_MAX_LEN) begin
                        w_ovf       = 1'b1;
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_DISCARD: begin
                if (rx_valid) begin
                    rx_rd = 1'b1;
                    w_pop = 1'b1;
                    if (w_is_term) begin
                        w_term = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                if ((r_dly + 16'd1) == c_DLY) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                tx_byte = w_rom_byte;
                if (!tx_full) begin
                    tx_wr = 1'b1;
                    if (r_idx == w_last_idx) begin
                        w_resp_done = 1'b1;
                        w_state_nxt = S_RECV;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_term) begin
            if (w_arm_drop) begin
                w_state_nxt = S_RECV;
            end else if (c_DLY == 16'd0) begin
                w_state_nxt = S_RESP;
            end else begin
                w_state_nxt = S_DELAY;
            end
        end

        // Abort wins over everything, effective at the next edge.
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end
    end

`ifdef BLE_RESP_FAULT_EN
    logic r_arm_err;
    logic r_arm_drop;

    // Sticky arms: consumed by the next completed line; a new pulse re-arms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arm_err  <= 1'b0;
            r_arm_drop <= 1'b0;
        end else begin
            if (w_term) begin
                r_arm_err  <= 1'b0;
                r_arm_drop <= 1'b0;
            end
            if (inject_err) begin
                r_arm_err <= 1'b1;
            end
            if (inject_drop) begin
                r_arm_drop <= 1'b1;
            end
        end
    end

    assign w_arm_err  = r_arm_err;
    assign w_arm_drop = r_arm_drop;
`else
    assign w_arm_err  = 1'b0;
    assign w_arm_drop = 1'b0;
`endif

    // State register and datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_a_seen     <= 1'b0;
            r_prefix_ok  <= 1'b0;
            r_last       <= 8'h00;
            r_verdict_ok <= 1'b0;
            r_dly        <= 16'd0;
            r_idx        <= 3'd0;
            r_overflow   <= 1'b0;
            r_ok_cnt     <= 8'h00;
            r_err_cnt    <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= w_ovf;

            // Line assembly state restarts from IDLE and after every terminator.
            if ((r_state == S_IDLE) || w_term) begin
                r_len       <= '0;
                r_a_seen    <= 1'b0;
                r_prefix_ok <= 1'b0;
                r_last      <= 8'h00;
            end else if (w_pop) begin
                r_last <= rx_byte;
                if (r_state == S_RECV) begin
                    r_len <= r_len + 1'b1;
                    if (r_len == '0) begin
                        r_a_seen <= (rx_byte == 8'h41);
                    end
                    if (r_len == c_LEN_W'(1)) begin
                        r_prefix_ok <= r_a_seen && (rx_byte == 8'h54);
                    end
                end
            end

            if (w_term) begin
                r_verdict_ok <= w_line_ok && !w_arm_err;
            end

            if (r_state != S_DELAY) begin
                r_dly <= 16'd0;
            end else begin
                r_dly <= r_dly + 16'd1;
            end

            if (r_state != S_RESP) begin
                r_idx <= 3'd0;
            end else if (tx_wr) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_resp_done) begin
                if (r_verdict_ok) begin
                    r_ok_cnt <= r_ok_cnt + 8'd1;
                end else begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign overflow  = r_overflow;
    assign ok_count  = r_ok_cnt;
    assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ble_at_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ble_at_responder
// Purpose  : Self-checking bench for ble_at_responder (MAX_CMD_LEN=32,
//            RESP_DELAY=4). Table of command lines with expected verdicts,
//            plus hand sequences for backpressure, abort, fault injection
//            (when BLE_RESP_FAULT_EN is defined) and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ble_at_responder;

    localparam int c_MAX = 32;
    localparam int c_DLY = 4;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_byte;
    logic       busy;
    logic       overflow;
    logic [7:0] ok_count;
    logic [7:0] err_count;
`ifdef BLE_RESP_FAULT_EN
    logic       inject_err;
    logic       inject_drop;
`endif

    ble_at_responder #(
        .MAX_CMD_LEN (c_MAX),
        .RESP_DELAY  (c_DLY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef BLE_RESP_FAULT_EN
        .inject_err  (inject_err),
        .inject_drop (inject_drop),
`endif
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_rd       (rx_rd),
        .tx_full     (tx_full),
        .tx_wr       (tx_wr),
        .tx_byte     (tx_byte),
        .busy        (busy),
        .overflow    (overflow),
        .ok_count    (ok_count),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RX FIFO model (first-word fall-through) -------------
    logic [7:0]  mem [0:4095];
    logic [15:0] wr_ptr = 16'd0;
    logic [15:0] rd_ptr = 16'd0;
    logic        pop_pending = 1'b0;

    assign rx_valid = (rd_ptr != wr_ptr);
    assign rx_byte  = mem[rd_ptr[11:0]];

    always @(posedge clk) begin
        if (pop_pending) rd_ptr <= rd_ptr + 16'd1;
    end

    // ---------------- Monitor (samples mid-cycle) -------------------------
    int         cyc = 0;
    logic [7:0] txq[$];
    int         txc[$];
    int         pops_total = 0;
    int         ovf_total = 0;
    int         ovf_at = -1;
    int         last_pop_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (overflow) begin
            ovf_total = ovf_total + 1;
            ovf_at    = pops_total;
        end
        if (rx_rd) begin
            pops_total   = pops_total + 1;
            last_pop_cyc = cyc;
        end
        pop_pending = rx_rd;
        if (tx_wr) begin
            txq.push_back(tx_byte);
            txc.push_back(cyc);
        end
    end

    // ---------------- Checking helpers ------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Loads a whole line into the RX FIFO just after a clock edge.
    task automatic push_line(input string s);
        @(posedge clk);
        #2;
        for (int i = 0; i < s.len(); i++) begin
            mem[wr_ptr[11:0]] = s[i];
            wr_ptr = wr_ptr + 16'd1;
        end
    endtask

    function automatic string mk_line(input int nx);
        string s;
        s = "AT";
        for (int i = 0; i < nx; i++) s = {s, "x"};
        s = {s, "\r\n"};
        return s;
    endfunction

    task automatic wait_count_change(input int ok0, input int er0, output int bound);
        bound = 0;
        while (int'(ok_count) == ok0 && int'(err_count) == er0 && bound < 400) begin
            @(negedge clk);
            #1;
            bound = bound + 1;
        end
    endtask

    task automatic run_line(input string s, input bit exp_ok, input int exp_ovf, input string tag);
        int    ok0, er0, bound, bad, tb0, pb0, ob0, n;
        string exp;
        if (exp_ok) exp = "OK\r\n";
        else        exp = "ERROR\r\n";
        tb0 = txq.size();
        pb0 = pops_total;
        ob0 = ovf_total;
        ok0 = int'(ok_count);
        er0 = int'(err_count);
        push_line(s);
        wait_count_change(ok0, er0, bound);
        check({tag, " completion"}, int'(bound < 400), 1);
        n   = txq.size() - tb0;
        bad = 0;
        for (int i = 0; i < exp.len(); i++)
            if (i >= n || txq[tb0 + i] != exp[i]) bad = bad + 1;
        check({tag, " resp_byte_mismatches"}, bad, 0);
        check({tag, " resp_len"}, n, exp.len());
        check({tag, " ok_delta"}, (int'(ok_count) - ok0) & 255, exp_ok ? 1 : 0);
        check({tag, " err_delta"}, (int'(err_count) - er0) & 255, exp_ok ? 0 : 1);
        check({tag, " overflow_pulses"}, ovf_total - ob0, exp_ovf);
        if (exp_ovf != 0) check({tag, " overflow_after_pop"}, ovf_at - pb0, c_MAX + 1);
        check({tag, " bytes_popped"}, pops_total - pb0, s.len());
        if (n > 0) begin
            check({tag, " latency"}, txc[tb0] - last_pop_cyc, 1 + c_DLY);
            check({tag, " back_to_back"}, txc[txq.size() - 1] - txc[tb0], n - 1);
        end
    endtask

    // ---------------- Vector table ----------------------------------------
    typedef struct {
        string line;
        bit    exp_ok;
        int    exp_ovf;
        string tag;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        int ok0, er0, bound, tb0;

        vecs[0] = '{"AT\r\n",       1'b1, 0, "at"};
        vecs[1] = '{"XY\r\n",       1'b0, 0, "xy"};
        vecs[2] = '{"AT+NAME\r\n",  1'b1, 0, "at_name"};
        vecs[3] = '{"\r\n",         1'b0, 0, "crlf_only"};
        vecs[4] = '{"A\r\n",        1'b0, 0, "a_only"};
        vecs[5] = '{"AT\n\r\n",     1'b1, 0, "lone_lf"};
        vecs[6] = '{mk_line(28),    1'b1, 0, "len32"};
        vecs[7] = '{mk_line(29),    1'b0, 0, "len33"};
        vecs[8] = '{mk_line(36),    1'b0, 1, "len40"};
        vecs[9] = '{"at\r\n",       1'b0, 0, "lowercase"};

        rst_n   = 1'b0;
        enable  = 1'b0;
        tx_full = 1'b0;
`ifdef BLE_RESP_FAULT_EN
        inject_err  = 1'b0;
        inject_drop = 1'b0;
`endif

        // Reset values
        repeat (3) @(negedge clk);
        check("reset rx_rd", rx_rd, 0);
        check("reset tx_wr", tx_wr, 0);
        check("reset tx_byte", tx_byte, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        check("reset ok_count", ok_count, 0);
        check("reset err_count", err_count, 0);

        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("busy with enable low", busy, 0);
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy after enable", busy, 1);

        // Table-driven lines
        for (int i = 0; i < 10; i++) begin
            run_line(vecs[i].line, vecs[i].exp_ok, vecs[i].exp_ovf, vecs[i].tag);
        end

        // Backpressure: tx_full for 3 cycles after the first byte
        tb0 = txq.size();
        ok0 = int'(ok_count);
        er0 = int'(err_count);
        push_line("AT\r\n");
        bound = 0;
        while (txq.size() == tb0 && bound < 100) begin
            @(negedge clk); #1;
            bound = bound + 1;
        end
        check("bp first byte seen", int'(bound < 100), 1);
        @(posedge clk); #1 tx_full = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_full = 1'b0;
        wait_count_change(ok0, er0, bound);
        check("bp completion", int'(bound < 400), 1);
        check("bp resp_len", txq.size() - tb0, 4);
        if (txq.size() - tb0 == 4) begin
            check("bp byte0", txq[tb0],     8'h4F);
            check("bp byte1", txq[tb0 + 1], 8'h4B);
            check("bp byte2", txq[tb0 + 2], 8'h0D);
            check("bp byte3", txq[tb0 + 3], 8'h0A);
            check("bp stall gap", txc[tb0 + 1] - txc[tb0], 4);
            check("bp total span", txc[tb0 + 3] - txc[tb0], 6);
        end
        check("bp ok_delta", (int'(ok_count) - ok0) & 255, 1);

        // Abort after the 2nd byte of an ERROR response
        tb0 = txq.size();
        ok0 = int'(ok_count);
        er0 = int'(err_count);
        push_line("XY\r\n");
        bound = 0;
        while (txq.size() - tb0 < 2 && bound < 100) begin
            @(negedge clk); #1;
            bound = bound + 1;
        end
        check("abort 2 bytes seen", int'(bound < 100), 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort tx_wr", tx_wr, 0);
        check("abort busy", busy, 0);
        repeat (6) @(negedge clk);
        #1;
        check("abort bytes sent", txq.size() - tb0, 2);
        check("abort err_count", int'(err_count), er0);
        check("abort ok_count", int'(ok_count), ok0);
        enable = 1'b1;
        run_line("AT\r\n", 1'b1, 0, "reenable");

`ifdef BLE_RESP_FAULT_EN
        // Drop: first line silently consumed, second answered
        @(posedge clk); #1 inject_drop = 1'b1;
        @(posedge clk); #1 inject_drop = 1'b0;
        tb0 = txq.size();
        ok0 = int'(ok_count);
        er0 = int'(err_count);
        push_line("AT\r\n");
        repeat (30) @(negedge clk);
        #1;
        check("drop no tx", txq.size() - tb0, 0);
        check("drop ok_count", int'(ok_count), ok0);
        check("drop err_count", int'(err_count), er0);
        check("drop line popped", int'(rx_valid), 0);
        run_line("AT\r\n", 1'b1, 0, "after_drop");
        @(posedge clk); #1 inject_err = 1'b1;
        @(posedge clk); #1 inject_err = 1'b0;
        run_line("AT\r\n", 1'b0, 0, "forced_err");
`endif

        // Counter wrap 0xFF -> 0x00
        bound = 0;
        while (ok_count != 8'hFF && bound < 300) begin
            ok0 = int'(ok_count);
            er0 = int'(err_count);
            push_line("AT\r\n");
            wait_count_change(ok0, er0, tb0);
            bound = bound + 1;
        end
        check("wrap reached 0xFF", ok_count, 8'hFF);
        run_line("AT\r\n", 1'b1, 0, "wrap");
        check("wrap value", ok_count, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
